// File: rtl/car_direction_detect.sv
// car_direction_detect
// Gate-sensor front end for the parking lot counter: synchronizes and
// debounces the outer/inner sensor levels, then tracks each crossing with a
// direction FSM that pulses enter/exit only for a complete, ordered crossing.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | both sensors clear, waiting for a new crossing
// IN1   | outer blocked only: possible entry starting
// IN2   | both blocked during an entry
// IN3   | inner blocked only: entry about to complete
// OUT1  | inner blocked only: possible exit starting
// OUT2  | both blocked during an exit
// OUT3  | outer blocked only: exit about to complete
// ABORT | illegal sequence seen, waiting for both sensors clear
module car_direction_detect #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic outer_raw,
    input  logic inner_raw,
    output logic outer_db,
    output logic inner_db,
    output logic enter,
    output logic exit,
    output logic err,
    output logic busy
);

    localparam int CW = $clog2(DB_CYCLES) + 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] IN1   = 3'd1;
    localparam logic [2:0] IN2   = 3'd2;
    localparam logic [2:0] IN3   = 3'd3;
    localparam logic [2:0] OUT1  = 3'd4;
    localparam logic [2:0] OUT2  = 3'd5;
    localparam logic [2:0] OUT3  = 3'd6;
    localparam logic [2:0] ABORT = 3'd7;

    logic outer_s1_q, outer_s1_d, outer_s2_q, outer_s2_d;
    logic inner_s1_q, inner_s1_d, inner_s2_q, inner_s2_d;
    logic [CW-1:0] outer_cnt_q, outer_cnt_d, inner_cnt_q, inner_cnt_d;
    logic outer_db_q, outer_db_d, inner_db_q, inner_db_d;
    logic [2:0] state_q, state_d;
    logic enter_q, enter_d, exit_q, exit_d, err_q, err_d, busy_q, busy_d;
    logic [1:0] ab;

    // Two-flop synchronizer chain per sensor.
    always_comb begin
        outer_s1_d = outer_raw;
        outer_s2_d = outer_s1_q;
        inner_s1_d = inner_raw;
        inner_s2_d = inner_s1_q;
    end

    // Debounce: the level only moves after DB_CYCLES consecutive mismatching cycles.
    always_comb begin
        outer_cnt_d = outer_cnt_q;
        outer_db_d  = outer_db_q;
        if (outer_s2_q == outer_db_q) begin
            outer_cnt_d = '0;
        end else if (outer_cnt_q == DB_LAST) begin
            outer_db_d  = outer_s2_q;
            outer_cnt_d = '0;
        end else begin
            outer_cnt_d = outer_cnt_q + 1'b1;
        end

        inner_cnt_d = inner_cnt_q;
        inner_db_d  = inner_db_q;
        if (inner_s2_q == inner_db_q) begin
            inner_cnt_d = '0;
        end else if (inner_cnt_q == DB_LAST) begin
            inner_db_d  = inner_s2_q;
            inner_cnt_d = '0;
        end else begin
            inner_cnt_d = inner_cnt_q + 1'b1;
        end
    end

    assign ab = {outer_db_q, inner_db_q};

    // Direction FSM next state and registered pulse/busy values.
    always_comb begin
        state_d = state_q;
        enter_d = 1'b0;
        exit_d  = 1'b0;
        case (state_q)
            IDLE: begin
                case (ab)
                    2'b10:   state_d = IN1;
                    2'b01:   state_d = OUT1;
                    2'b11:   state_d = ABORT;
                    default: state_d = IDLE;
                endcase
            end
            IN1: begin
                case (ab)
                    2'b10:   state_d = IN1;
                    2'b11:   state_d = IN2;
                    2'b00:   state_d = IDLE;
                    default: state_d = ABORT;
                endcase
            end
            IN2: begin
                case (ab)
                    2'b11:   state_d = IN2;
                    2'b01:   state_d = IN3;
                    2'b10:   state_d = IN1;
                    default: state_d = ABORT;
                endcase
            end
            IN3: begin
                case (ab)
                    2'b01:   state_d = IN3;
                    2'b11:   state_d = IN2;
                    2'b00: begin
                        state_d = IDLE;
                        enter_d = 1'b1;
                    end
                    default: state_d = ABORT;
                endcase
            end
            OUT1: begin
                case (ab)
                    2'b01:   state_d = OUT1;
                    2'b11:   state_d = OUT2;
                    2'b00:   state_d = IDLE;
                    default: state_d = ABORT;
                endcase
            end
            OUT2: begin
                case (ab)
                    2'b11:   state_d = OUT2;
                    2'b10:   state_d = OUT3;
                    2'b01:   state_d = OUT1;
                    default: state_d = ABORT;
                endcase
            end
            OUT3: begin
                case (ab)
                    2'b10:   state_d = OUT3;
                    2'b11:   state_d = OUT2;
                    2'b00: begin
                        state_d = IDLE;
                        exit_d  = 1'b1;
                    end
                    default: state_d = ABORT;
                endcase
            end
            default: begin
                if (ab == 2'b00) begin
                    state_d = IDLE;
                end else begin
                    state_d = ABORT;
                end
            end
        endcase
        // err marks entry into ABORT only, so lingering there stays quiet.
        err_d  = (state_d == ABORT) && (state_q != ABORT);
        busy_d = (state_d != IDLE);
    end

    // All state elements; reset clears every stage so a partial crossing is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outer_s1_q  <= 1'b0;
            outer_s2_q  <= 1'b0;
            inner_s1_q  <= 1'b0;
            inner_s2_q  <= 1'b0;
            outer_cnt_q <= '0;
            inner_cnt_q <= '0;
            outer_db_q  <= 1'b0;
            inner_db_q  <= 1'b0;
            state_q     <= IDLE;
            enter_q     <= 1'b0;
            exit_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            outer_s1_q  <= outer_s1_d;
            outer_s2_q  <= outer_s2_d;
            inner_s1_q  <= inner_s1_d;
            inner_s2_q  <= inner_s2_d;
            outer_cnt_q <= outer_cnt_d;
            inner_cnt_q <= inner_cnt_d;
            outer_db_q  <= outer_db_d;
            inner_db_q  <= inner_db_d;
            state_q     <= state_d;
            enter_q     <= enter_d;
            exit_q      <= exit_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign outer_db = outer_db_q;
    assign inner_db = inner_db_q;
    assign enter    = enter_q;
    assign exit     = exit_q;
    assign err      = err_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_car_direction_detect.sv
// Directed bench for car_direction_detect with DB_CYCLES = 4.
module tb_car_direction_detect;

    logic clk = 1'b0;
    logic reset;
    logic outer_raw, inner_raw;
    logic outer_db, inner_db, enter, exit, err, busy;

    int n_cmp = 0;
    int n_bad = 0;

    int n_enter = 0, n_exit = 0, n_err = 0, n_odb = 0, n_busy = 0, n_viol = 0;
    logic prev_enter = 1'b0, prev_exit = 1'b0, prev_err = 1'b0;

    car_direction_detect #(.DB_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .outer_raw (outer_raw),
        .inner_raw (inner_raw),
        .outer_db  (outer_db),
        .inner_db  (inner_db),
        .enter     (enter),
        .exit      (exit),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Running tallies of output activity, sampled away from the active edge.
    always @(negedge clk) begin
        if (enter)    n_enter++;
        if (exit)     n_exit++;
        if (err)      n_err++;
        if (outer_db) n_odb++;
        if (busy)     n_busy++;
        if ((int'(enter) + int'(exit) + int'(err)) > 1) n_viol++;
        if ((enter && prev_enter) || (exit && prev_exit) || (err && prev_err)) n_viol++;
        prev_enter = enter;
        prev_exit  = exit;
        prev_err   = err;
    end

    task automatic drive(input logic o, input logic i, input int n);
        outer_raw = o;
        inner_raw = i;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        int b_err;
        b_err = n_err;
        reset = 1'b0;
        outer_raw = 1'b1;
        inner_raw = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({outer_db, inner_db, enter, exit, err, busy} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 000000", {outer_db, inner_db, enter, exit, err, busy});
        end
        reset = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({outer_db, inner_db} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_db_early: got %b want 00", {outer_db, inner_db});
        end
        @(negedge clk);
        n_cmp++;
        if ({outer_db, inner_db, err, busy} !== 4'b1100) begin
            n_bad++;
            $display("FAIL reset_db_rise: got %b want 1100", {outer_db, inner_db, err, busy});
        end
        @(negedge clk);
        n_cmp++;
        if ({err, busy} !== 2'b11) begin
            n_bad++;
            $display("FAIL reset_abort_err: got %b want 11", {err, busy});
        end
        @(negedge clk);
        n_cmp++;
        if ({err, busy} !== 2'b01) begin
            n_bad++;
            $display("FAIL reset_abort_hold: got %b want 01", {err, busy});
        end
        drive(1'b0, 1'b0, 12);
        n_cmp++;
        if (busy !== 1'b0 || (n_err - b_err) != 1) begin
            n_bad++;
            $display("FAIL reset_abort_exit: busy %b err_count %0d want busy 0 err_count 1", busy, n_err - b_err);
        end
    endtask

    task automatic test_entry();
        int b_en, b_ex, b_er;
        b_en = n_enter; b_ex = n_exit; b_er = n_err;
        drive(1'b1, 1'b0, 10);
        drive(1'b1, 1'b1, 10);
        drive(1'b0, 1'b1, 10);
        drive(1'b0, 1'b0, 6);
        n_cmp++;
        if (enter !== 1'b0) begin
            n_bad++;
            $display("FAIL entry_early: enter %b want 0", enter);
        end
        @(negedge clk);
        n_cmp++;
        if ({enter, exit, err, busy} !== 4'b1000) begin
            n_bad++;
            $display("FAIL entry_pulse: got %b want 1000", {enter, exit, err, busy});
        end
        @(negedge clk);
        n_cmp++;
        if (enter !== 1'b0) begin
            n_bad++;
            $display("FAIL entry_width: enter %b want 0", enter);
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if ((n_enter - b_en) != 1 || (n_exit - b_ex) != 0 || (n_err - b_er) != 0) begin
            n_bad++;
            $display("FAIL entry_counts: enter %0d exit %0d err %0d want 1 0 0",
                     n_enter - b_en, n_exit - b_ex, n_err - b_er);
        end
    endtask

    task automatic test_exit();
        int b_en, b_ex, b_er;
        b_en = n_enter; b_ex = n_exit; b_er = n_err;
        drive(1'b0, 1'b1, 10);
        drive(1'b1, 1'b1, 10);
        drive(1'b1, 1'b0, 10);
        drive(1'b0, 1'b0, 12);
        n_cmp++;
        if ((n_enter - b_en) != 0 || (n_exit - b_ex) != 1 || (n_err - b_er) != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL exit_counts: enter %0d exit %0d err %0d busy %b want 0 1 0 0",
                     n_enter - b_en, n_exit - b_ex, n_err - b_er, busy);
        end
    endtask

    task automatic test_pedestrian_backing();
        int b_en, b_ex, b_er;
        b_en = n_enter; b_ex = n_exit; b_er = n_err;
        drive(1'b1, 1'b0, 10);
        drive(1'b0, 1'b0, 10);
        drive(1'b0, 1'b1, 10);
        drive(1'b0, 1'b0, 12);
        n_cmp++;
        if ((n_enter - b_en) != 0 || (n_exit - b_ex) != 0 || (n_err - b_er) != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL pedestrian: enter %0d exit %0d err %0d busy %b want 0 0 0 0",
                     n_enter - b_en, n_exit - b_ex, n_err - b_er, busy);
        end
        b_en = n_enter; b_ex = n_exit; b_er = n_err;
        drive(1'b1, 1'b0, 10);
        drive(1'b1, 1'b1, 10);
        drive(1'b1, 1'b0, 10);
        drive(1'b0, 1'b0, 12);
        n_cmp++;
        if ((n_enter - b_en) != 0 || (n_exit - b_ex) != 0 || (n_err - b_er) != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL backing_out: enter %0d exit %0d err %0d busy %b want 0 0 0 0",
                     n_enter - b_en, n_exit - b_ex, n_err - b_er, busy);
        end
        b_en = n_enter; b_ex = n_exit; b_er = n_err;
        drive(1'b1, 1'b0, 10);
        drive(1'b1, 1'b1, 10);
        drive(1'b0, 1'b1, 10);
        drive(1'b1, 1'b1, 10);
        drive(1'b0, 1'b1, 10);
        drive(1'b0, 1'b0, 12);
        n_cmp++;
        if ((n_enter - b_en) != 1 || (n_exit - b_ex) != 0 || (n_err - b_er) != 0) begin
            n_bad++;
            $display("FAIL wiggle_entry: enter %0d exit %0d err %0d want 1 0 0",
                     n_enter - b_en, n_exit - b_ex, n_err - b_er);
        end
    endtask

    task automatic test_glitch();
        int b_odb, b_busy, b_en, b_ex, b_er;
        b_odb = n_odb; b_busy = n_busy;
        drive(1'b1, 1'b0, 3);
        drive(1'b0, 1'b0, 15);
        n_cmp++;
        if ((n_odb - b_odb) != 0 || (n_busy - b_busy) != 0) begin
            n_bad++;
            $display("FAIL glitch_3: outer_db cycles %0d busy cycles %0d want 0 0", n_odb - b_odb, n_busy - b_busy);
        end
        b_odb = n_odb; b_busy = n_busy;
        b_en = n_enter; b_ex = n_exit; b_er = n_err;
        drive(1'b1, 1'b0, 4);
        drive(1'b0, 1'b0, 15);
        n_cmp++;
        if ((n_odb - b_odb) != 4 || (n_busy - b_busy) != 4) begin
            n_bad++;
            $display("FAIL glitch_4: outer_db cycles %0d busy cycles %0d want 4 4", n_odb - b_odb, n_busy - b_busy);
        end
        n_cmp++;
        if ((n_enter - b_en) != 0 || (n_exit - b_ex) != 0 || (n_err - b_er) != 0) begin
            n_bad++;
            $display("FAIL glitch_4_pulses: enter %0d exit %0d err %0d want 0 0 0",
                     n_enter - b_en, n_exit - b_ex, n_err - b_er);
        end
    endtask

    task automatic test_illegal();
        int b_en, b_er;
        b_en = n_enter; b_er = n_err;
        drive(1'b1, 1'b0, 10);
        drive(1'b0, 1'b1, 10);
        n_cmp++;
        if ((n_err - b_er) != 1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL illegal_swap: err %0d busy %b want 1 1", n_err - b_er, busy);
        end
        drive(1'b0, 1'b0, 12);
        n_cmp++;
        if (busy !== 1'b0 || (n_err - b_er) != 1) begin
            n_bad++;
            $display("FAIL illegal_recover: busy %b err %0d want 0 1", busy, n_err - b_er);
        end
        drive(1'b1, 1'b0, 10);
        drive(1'b1, 1'b1, 10);
        drive(1'b0, 1'b1, 10);
        drive(1'b0, 1'b0, 12);
        n_cmp++;
        if ((n_enter - b_en) != 1 || (n_err - b_er) != 1) begin
            n_bad++;
            $display("FAIL illegal_then_entry: enter %0d err %0d want 1 1", n_enter - b_en, n_err - b_er);
        end
    endtask

    task automatic test_reset_mid();
        int b_en, b_ex, b_er;
        b_en = n_enter; b_ex = n_exit; b_er = n_err;
        drive(1'b1, 1'b0, 10);
        drive(1'b1, 1'b1, 10);
        n_cmp++;
        if ({outer_db, inner_db, busy} !== 3'b111) begin
            n_bad++;
            $display("FAIL mid_in2: got %b want 111", {outer_db, inner_db, busy});
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({outer_db, inner_db, enter, exit, err, busy} !== 6'b0) begin
            n_bad++;
            $display("FAIL mid_async_reset: got %b want 000000", {outer_db, inner_db, enter, exit, err, busy});
        end
        outer_raw = 1'b0;
        inner_raw = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, 20);
        n_cmp++;
        if ((n_enter - b_en) != 0 || (n_exit - b_ex) != 0 || (n_err - b_er) != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_after_release: enter %0d exit %0d err %0d busy %b want 0 0 0 0",
                     n_enter - b_en, n_exit - b_ex, n_err - b_er, busy);
        end
    endtask

    task automatic test_pulse_rules();
        n_cmp++;
        if (n_viol != 0) begin
            n_bad++;
            $display("FAIL pulse_rules: violations %0d want 0", n_viol);
        end
    endtask

    initial begin
        reset = 1'b0;
        outer_raw = 1'b1;
        inner_raw = 1'b1;
        test_reset();
        test_entry();
        test_exit();
        test_pedestrian_backing();
        test_glitch();
        test_illegal();
        test_reset_mid();
        test_pulse_rules();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/car_direction_detect.md
# car_direction_detect

Upstream front end for `parking_lot_occupancy`. Takes the raw outer and inner gate-sensor levels from the GPIO header, synchronizes and debounces them, and tracks each crossing with a direction FSM. It emits a single-cycle `enter` or `exit` pulse only for a complete, ordered car crossing. Pedestrians, backing out, and illegal sequences produce no count pulse.

## Interface
- `DB_CYCLES`, default 4: consecutive stable cycles required before a debounced level changes. Must be ≥1. Use 500000 on the board (10 ms at 50 MHz).
- `clk`  in  1  system clock (CLOCK_50)
- `reset`  in  1  asynchronous, active-low reset
- `outer_raw`  in  1  outer sensor, 1 = blocked, asynchronous to clk
- `inner_raw`  in  1  inner sensor, 1 = blocked, asynchronous to clk
- `outer_db`  out  1  debounced outer level (drives LED)
- `inner_db`  out  1  debounced inner level (drives LED)
- `enter`  out  1  one-cycle pulse: car completed entry
- `exit`  out  1  one-cycle pulse: car completed exit
- `err`  out  1  one-cycle pulse: illegal sequence detected
- `busy`  out  1  FSM not in IDLE (registered)

## Operation
- Synchronizer: two flops per sensor, `*_raw` → `s1` → `s2`.
- Debouncer, per sensor: counter of width clog2(DB_CYCLES)+1.
  - If `s2 == db`: counter ← 0.
  - Else if counter == DB_CYCLES−1: db ← s2, counter ← 0.
  - Else: counter ← counter+1.
  - A glitch shorter than DB_CYCLES cycles at s2 never reaches db.
- FSM input `ab = {outer_db, inner_db}`. States: IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, ABORT.
- IDLE: 10→IN1; 01→OUT1; 11→ABORT; 00 stay.
- IN1: 10 stay; 11→IN2; 00→IDLE (no pulse); 01→ABORT.
- IN2: 11 stay; 01→IN3; 10→IN1; 00→ABORT.
- IN3: 01 stay; 11→IN2; 00→IDLE with `enter`; 10→ABORT.
- OUT1, OUT2, OUT3: mirror of IN1, IN2, IN3 with outer and inner swapped. OUT3 with 00 goes to IDLE with `exit`.
- ABORT: stay until ab == 00, then IDLE.
- Pulses:
  - `err` pulses on every transition into ABORT, never while remaining in ABORT.
  - `enter`, `exit`, and `err` are registered and updated on the same edge as the state. They are mutually exclusive and never high two cycles in a row.
- Two sensors changing in the same cycle (e.g. 10→01) is handled by the table above; no special case.

## Timing
- Reset asserted: immediately, and asynchronously, all sync flops = 0, counters = 0, `outer_db = inner_db = 0`, state = IDLE, and `enter = exit = err = busy = 0`.
- Reset mid-sequence: the partial crossing is discarded and no pulse is emitted.
- After reset release with a sensor still blocked: db rises after debounce. The FSM then treats it as a fresh sequence (e.g. 11 → ABORT, `err`).
- Latency, for a raw level stable from before rising edge k:
  - s2 updates after edge k+1.
  - db updates after edge k+DB_CYCLES+1.
  - FSM state, `busy`, and pulses update after edge k+DB_CYCLES+2.
- Pulse width is exactly 1 clk.
- Minimum time between two completed crossings is 4 × (DB_CYCLES+1) cycles; no crossings are lost at this rate.

## Test plan
All scenarios use DB_CYCLES=4 and hold each level for 10 cycles unless stated.
- Reset: hold reset=0 with both raw=1 → all outputs 0 during reset. Release → `outer_db` and `inner_db` rise 6 cycles after release; FSM goes IDLE→ABORT; `err` pulses once; `busy` = 1 until both raw return to 0.
- Entry: raw sequence 10,11,01,00 → exactly one `enter` pulse, 6 cycles after the edge where raw becomes 00; `exit` and `err` stay 0. Exit sequence 01,11,10,00 → exactly one `exit` pulse.
- Pedestrian and backing:
  - 10,00,01,00 → no pulses, FSM back in IDLE.
  - 10,11,10,00 (car backs out) → no pulses.
  - 10,11,01,11,01,00 → exactly one `enter`.
- Glitch filter: 3-cycle high pulse on `outer_raw` → `outer_db` never changes, no FSM activity. 4-cycle pulse → `outer_db` high for exactly 4 cycles.
- Illegal sequence: 10,01 (simultaneous swap) → `err` once, state ABORT. Then 00 → IDLE. Then a full entry → `enter`.
- Reset mid-crossing: assert reset while in IN2 → no pulse. Release with raw=00 → IDLE, `busy` = 0.
